// File: rtl/rip_encode_if.sv
// Request/response bundle for the RV32IM instruction encoder.
// slave is the encoder's view; master is the requester/consumer.
interface rip_encode_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [5:0]                op_id;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [31:0]               imm;
    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_code;
    logic [1:0]                out_err;

    modport master (
        output in_valid, op_id, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out_code, out_err
    );

    modport slave (
        input  in_valid, op_id, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out_code, out_err
    );
endinterface

// File: rtl/rip_encode.sv
// Two-stage elastic encoder: mnemonic ID + operands -> 32-bit RV32IM word.
// Illegal IDs and out-of-range immediates produce NOP_CODE plus an error code.
module rip_encode #(
    parameter int          REG_ADDR_WIDTH = 5,
    parameter int          CNT_WIDTH      = 16,
    parameter logic [31:0] NOP_CODE       = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    rip_encode_if.slave          bus,
    output logic [CNT_WIDTH-1:0] enc_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam logic [3:0] FMT_U   = 4'd0;
    localparam logic [3:0] FMT_J   = 4'd1;
    localparam logic [3:0] FMT_I   = 4'd2;
    localparam logic [3:0] FMT_B   = 4'd3;
    localparam logic [3:0] FMT_S   = 4'd4;
    localparam logic [3:0] FMT_SH  = 4'd5;
    localparam logic [3:0] FMT_R   = 4'd6;
    localparam logic [3:0] FMT_CSR = 4'd7;
    localparam logic [3:0] FMT_SYS = 4'd8;
    localparam logic [3:0] FMT_ILL = 4'd9;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_OP  = 2'b01;
    localparam logic [1:0] ERR_IMM = 2'b10;

    function automatic logic [3:0] classify(input logic [5:0] op);
        case (op) inside
            [6'd0:6'd1]:   return FMT_U;
            6'd2:          return FMT_J;
            6'd3:          return FMT_I;
            [6'd4:6'd9]:   return FMT_B;
            [6'd10:6'd14]: return FMT_I;
            [6'd15:6'd17]: return FMT_S;
            [6'd18:6'd23]: return FMT_I;
            [6'd24:6'd26]: return FMT_SH;
            [6'd27:6'd36]: return FMT_R;
            [6'd37:6'd38]: return FMT_I;
            [6'd39:6'd41]: return FMT_SYS;
            [6'd42:6'd47]: return FMT_CSR;
            [6'd48:6'd55]: return FMT_R;
            default:       return FMT_ILL;
        endcase
    endfunction

    // True when v is representable as a two's-complement value of 'bits' bits.
    function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned bits);
        logic signed [31:0] t;
        t = v >>> (bits - 1);
        return (t == '0) || (t == '1);
    endfunction

    function automatic logic imm_ok(input logic [3:0] fmt, input logic [31:0] imm);
        case (fmt)
            FMT_U:   return imm[11:0] == 12'd0;
            FMT_J:   return fits_signed(imm, 21) && !imm[0];
            FMT_I:   return fits_signed(imm, 12);
            FMT_B:   return fits_signed(imm, 13) && !imm[0];
            FMT_S:   return fits_signed(imm, 12);
            FMT_SH:  return imm[31:5] == 27'd0;
            FMT_CSR: return imm[31:12] == 20'd0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [3:0]                fmt_p0;
    logic [1:0]                err_p0;
    logic                      accept;
    logic                      load_p2;
    logic                      hs;

    logic                      vld_p1;
    logic [5:0]                op_p1;
    logic [3:0]                fmt_p1;
    logic [1:0]                err_p1;
    logic [REG_ADDR_WIDTH-1:0] rd_p1;
    logic [REG_ADDR_WIDTH-1:0] rs1_p1;
    logic [REG_ADDR_WIDTH-1:0] rs2_p1;
    logic [31:0]               imm_p1;

    logic [6:0]                opc;
    logic [2:0]                f3;
    logic [6:0]                f7;
    logic [4:0]                rd5;
    logic [4:0]                rs15;
    logic [4:0]                rs25;
    logic [31:0]               word_p1;

    logic                      vld_p2;
    logic [31:0]               code_p2;
    logic [1:0]                err_p2;

    assign fmt_p0 = classify(bus.op_id);
    assign err_p0 = (fmt_p0 == FMT_ILL) ? ERR_OP :
                    (imm_ok(fmt_p0, bus.imm) ? ERR_OK : ERR_IMM);

    assign load_p2      = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !flush && (!vld_p1 || load_p2);
    assign accept       = bus.in_valid && bus.in_ready;
    assign hs           = vld_p2 && bus.out_ready;

    // ---- stage 1: register request with its format and error class ----
    always_ff @(posedge clk) begin
        if (!rst_n)                 vld_p1 <= 1'b0;
        else if (flush)             vld_p1 <= 1'b0;
        else if (!vld_p1 || load_p2) vld_p1 <= bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1  <= bus.op_id;
            fmt_p1 <= fmt_p0;
            err_p1 <= err_p0;
            rd_p1  <= bus.rd;
            rs1_p1 <= bus.rs1;
            rs2_p1 <= bus.rs2;
            imm_p1 <= bus.imm;
        end
    end

    assign rd5  = 5'(rd_p1);
    assign rs15 = 5'(rs1_p1);
    assign rs25 = 5'(rs2_p1);

    always_comb begin
        opc = 7'h13;
        case (op_p1) inside
            6'd0:          opc = 7'h37;
            6'd1:          opc = 7'h17;
            6'd2:          opc = 7'h6F;
            6'd3:          opc = 7'h67;
            [6'd4:6'd9]:   opc = 7'h63;
            [6'd10:6'd14]: opc = 7'h03;
            [6'd15:6'd17]: opc = 7'h23;
            [6'd18:6'd26]: opc = 7'h13;
            [6'd27:6'd36]: opc = 7'h33;
            [6'd37:6'd38]: opc = 7'h0F;
            [6'd39:6'd47]: opc = 7'h73;
            [6'd48:6'd55]: opc = 7'h33;
            default:       opc = 7'h13;
        endcase

        f3 = 3'd0;
        case (op_p1)
            6'd5, 6'd11, 6'd16, 6'd24, 6'd29, 6'd38, 6'd42, 6'd49:        f3 = 3'd1;
            6'd12, 6'd17, 6'd19, 6'd30, 6'd43, 6'd50:                     f3 = 3'd2;
            6'd20, 6'd31, 6'd44, 6'd51:                                   f3 = 3'd3;
            6'd6, 6'd13, 6'd21, 6'd32, 6'd52:                             f3 = 3'd4;
            6'd7, 6'd14, 6'd25, 6'd26, 6'd33, 6'd34, 6'd45, 6'd53:        f3 = 3'd5;
            6'd8, 6'd22, 6'd35, 6'd46, 6'd54:                             f3 = 3'd6;
            6'd9, 6'd23, 6'd36, 6'd47, 6'd55:                             f3 = 3'd7;
            default:                                                      f3 = 3'd0;
        endcase

        f7 = 7'h00;
        if (op_p1 == 6'd26 || op_p1 == 6'd28 || op_p1 == 6'd34) f7 = 7'h20;
        else if (op_p1 >= 6'd48 && op_p1 <= 6'd55)               f7 = 7'h01;

        word_p1 = NOP_CODE;
        case (fmt_p1)
            FMT_U:   word_p1 = {imm_p1[31:12], rd5, opc};
            FMT_J:   word_p1 = {imm_p1[20], imm_p1[10:1], imm_p1[11], imm_p1[19:12], rd5, opc};
            FMT_I,
            FMT_CSR: word_p1 = {imm_p1[11:0], rs15, f3, rd5, opc};
            FMT_B:   word_p1 = {imm_p1[12], imm_p1[10:5], rs25, rs15, f3, imm_p1[4:1], imm_p1[11], opc};
            FMT_S:   word_p1 = {imm_p1[11:5], rs25, rs15, f3, imm_p1[4:0], opc};
            FMT_SH:  word_p1 = {f7, imm_p1[4:0], rs15, f3, rd5, opc};
            FMT_R:   word_p1 = {f7, rs25, rs15, f3, rd5, opc};
            FMT_SYS: begin
                case (op_p1)
                    6'd39:   word_p1 = 32'h0000_0073;
                    6'd40:   word_p1 = 32'h0010_0073;
                    default: word_p1 = 32'h3020_0073;
                endcase
            end
            default: word_p1 = NOP_CODE;
        endcase
        if (err_p1 != ERR_OK) word_p1 = NOP_CODE;
    end

    // ---- stage 2: register assembled word; held while the consumer stalls ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            code_p2 <= '0;
            err_p2  <= '0;
        end else begin
            if (flush)        vld_p2 <= 1'b0;
            else if (load_p2) vld_p2 <= vld_p1;
            if (load_p2 && vld_p1 && !flush) begin
                code_p2 <= word_p1;
                err_p2  <= err_p1;
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_code  = code_p2;
    assign bus.out_err   = err_p2;

    // A word leaving during a flush cycle still counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (hs) begin
            enc_count <= enc_count + 1'b1;
            if (err_p2 != ERR_OK) err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_rip_encode.sv
// Bench for rip_encode: directed scenarios plus random traffic against an arithmetic reference encoder.
module tb_rip_encode;

    typedef struct packed {
        logic [31:0] code;
        logic [1:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    rip_encode_if #(.REG_ADDR_WIDTH(5)) ifc ();

    rip_encode #(
        .REG_ADDR_WIDTH(5),
        .CNT_WIDTH(16),
        .NOP_CODE(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(ifc),
        .enc_count(enc_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Instruction formats per op_id 0..55: U J I B S H(shift) R E(fixed system) C(csr)
    string FMT = "UUJIBBBBBBIIIIISSSIIIIIIHHHRRRRRRRRRRIIEEECCCCCCRRRRRRRR";
    int F3 [56] = '{0,0,0,0, 0,1,4,5,6,7, 0,1,2,4,5, 0,1,2, 0,2,3,4,6,7, 1,5,5,
                    0,0,1,2,3,4,5,5,6,7, 0,1, 0,0,0, 1,2,3,5,6,7, 0,1,2,3,4,5,6,7};

    exp_t        sb[$];
    logic        req_valid = 0, req_ordy = 0, req_flush = 0, req_rstn = 0;
    logic [5:0]  req_op = 0;
    logic [4:0]  req_rd = 0, req_rs1 = 0, req_rs2 = 0;
    logic [31:0] req_imm = 0;
    logic        kat_en = 0;
    logic [31:0] kat_code = 0;
    logic [1:0]  kat_err = 0;
    logic        last_acc = 0, last_hs = 0;
    logic        hold_prev = 0;
    logic [31:0] hold_code = 0;
    logic [1:0]  hold_err = 0;
    logic [15:0] enc_m = 0, err_m = 0;
    int          hs_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_enc(input int op, input logic [4:0] d, s1, s2,
                                    input logic [31:0] im,
                                    output logic [31:0] code, output logic [1:0] err);
        longint u, s, w, lo, opc, f3, f7;
        bit ok;
        byte f;
        u = longint'(im);
        s = longint'($signed(im));
        if (op > 55) begin code = 32'h13; err = 2'b01; return; end
        f  = FMT.getc(op);
        f3 = F3[op];
        f7 = (op == 26 || op == 28 || op == 34) ? 'h20 : (op >= 48 ? 1 : 0);
        if (op == 0) opc = 'h37; else if (op == 1) opc = 'h17; else if (op == 2) opc = 'h6F;
        else if (op == 3) opc = 'h67; else if (op <= 9) opc = 'h63; else if (op <= 14) opc = 'h03;
        else if (op <= 17) opc = 'h23; else if (op <= 26) opc = 'h13; else if (op <= 36) opc = 'h33;
        else if (op <= 38) opc = 'h0F; else if (op <= 47) opc = 'h73; else opc = 'h33;
        ok = 1; w = 0;
        case (f)
            "U": begin ok = (u % 4096) == 0; w = u + d * 128 + opc; end
            "J": begin
                ok = s >= -1048576 && s <= 1048575 && (u % 2) == 0;
                lo = u % 2097152;
                w = (lo / 1048576) * (64'd1 << 31) + ((lo / 2) % 1024) * (64'd1 << 21)
                  + ((lo / 2048) % 2) * (64'd1 << 20) + ((lo / 4096) % 256) * 4096 + d * 128 + opc;
            end
            "I": begin ok = s >= -2048 && s <= 2047; w = (u % 4096) * (64'd1 << 20) + s1 * 32768 + f3 * 4096 + d * 128 + opc; end
            "B": begin
                ok = s >= -4096 && s <= 4095 && (u % 2) == 0;
                lo = u % 8192;
                w = (lo / 4096) * (64'd1 << 31) + ((lo / 32) % 64) * (64'd1 << 25) + s2 * (64'd1 << 20)
                  + s1 * 32768 + f3 * 4096 + ((lo / 2) % 16) * 256 + ((lo / 2048) % 2) * 128 + opc;
            end
            "S": begin
                ok = s >= -2048 && s <= 2047;
                lo = u % 4096;
                w = (lo / 32) * (64'd1 << 25) + s2 * (64'd1 << 20) + s1 * 32768 + f3 * 4096 + (lo % 32) * 128 + opc;
            end
            "H": begin ok = u < 32; w = f7 * (64'd1 << 25) + u * (64'd1 << 20) + s1 * 32768 + f3 * 4096 + d * 128 + opc; end
            "R": w = f7 * (64'd1 << 25) + s2 * (64'd1 << 20) + s1 * 32768 + f3 * 4096 + d * 128 + opc;
            "C": begin ok = u < 4096; w = u * (64'd1 << 20) + s1 * 32768 + f3 * 4096 + d * 128 + opc; end
            default: w = (op == 39) ? 'h73 : (op == 40) ? 'h100073 : 'h30200073;
        endcase
        if (ok) begin code = w[31:0]; err = 2'b00; end
        else    begin code = 32'h13;  err = 2'b10; end
    endfunction

    // One clock: apply pending inputs, then sample mid-cycle and update the scoreboard.
    task automatic step();
        exp_t        e;
        logic [31:0] c;
        logic [1:0]  r;
        @(negedge clk);
        ifc.in_valid  = req_valid;
        ifc.op_id     = req_op;
        ifc.rd        = req_rd;
        ifc.rs1       = req_rs1;
        ifc.rs2       = req_rs2;
        ifc.imm       = req_imm;
        ifc.out_ready = req_ordy;
        flush         = req_flush;
        rst_n         = req_rstn;
        #1;
        if (hold_prev) begin
            check("hold_valid", ifc.out_valid, 1);
            check("hold_code", ifc.out_code, hold_code);
            check("hold_err", ifc.out_err, hold_err);
        end
        check("enc_count", enc_count, enc_m);
        check("err_count", err_count, err_m);
        if (!req_rstn) begin
            sb.delete();
            enc_m = 0; err_m = 0;
            last_acc = 0; last_hs = 0; hold_prev = 0;
            return;
        end
        last_hs  = ifc.out_valid && ifc.out_ready;
        last_acc = ifc.in_valid && ifc.in_ready;
        if (req_flush) check("in_ready_in_flush", ifc.in_ready, 0);
        if (last_hs) begin
            hs_total++;
            check("word_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_code", ifc.out_code, e.code);
                check("out_err", ifc.out_err, e.err);
                enc_m = enc_m + 1'b1;
                if (e.err != 2'b00 && err_m != 16'hFFFF) err_m = err_m + 1'b1;
            end
        end
        if (req_flush) sb.delete();
        if (last_acc) begin
            if (kat_en) begin
                e.code = kat_code; e.err = kat_err; kat_en = 0;
            end else begin
                ref_enc(int'(req_op), req_rd, req_rs1, req_rs2, req_imm, c, r);
                e.code = c; e.err = r;
            end
            sb.push_back(e);
        end
        hold_prev = ifc.out_valid && !ifc.out_ready && !req_flush;
        hold_code = ifc.out_code;
        hold_err  = ifc.out_err;
    endtask

    task automatic set_req(input logic v, input int op, input int d, input int s1, input int s2,
                           input logic [31:0] im);
        req_valid = v; req_op = 6'(op); req_rd = 5'(d); req_rs1 = 5'(s1); req_rs2 = 5'(s2); req_imm = im;
    endtask

    task automatic set_kat(input logic [31:0] c, input logic [1:0] e);
        kat_en = 1; kat_code = c; kat_err = e;
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && sb.size() != 0; t++) step();
        step();
        check("drain_empty", sb.size(), 0);
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 6))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
            2:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            3:       return 32'($urandom_range(0, 2097151)) - 32'd1048576;
            4:       return 32'($urandom_range(0, 40));
            5:       return $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_F000);
            default: return 32'($urandom_range(0, 5000));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int idx, hs0, bp_op[3], bp_im[3];
        logic [15:0] enc_before;

        ifc.in_valid = 0; ifc.op_id = 0; ifc.rd = 0; ifc.rs1 = 0; ifc.rs2 = 0;
        ifc.imm = 0; ifc.out_ready = 0;

        req_rstn = 0;
        repeat (3) step();
        req_rstn = 1; req_ordy = 1;
        step();
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_out_code", ifc.out_code, 0);
        check("rst_out_err", ifc.out_err, 0);
        check("rst_in_ready", ifc.in_ready, 1);

        // ADDI x1,x2,-1 with latency check
        set_req(1, 18, 1, 2, 0, 32'hFFFF_FFFF); set_kat(32'hFFF1_0093, 2'b00);
        step(); check("addi_accept", last_acc, 1);
        req_valid = 0;
        step(); check("addi_lat1", ifc.out_valid, 0);
        step(); check("addi_lat2", ifc.out_valid, 1);
        step(); check("addi_enc_count", enc_count, 1);

        // back-to-back stream
        hs0 = hs_total;
        set_req(1, 4, 0, 1, 2, 32'd8);     set_kat(32'h0020_8463, 2'b00); step(); check("beq_accept", last_acc, 1);
        set_req(1, 26, 3, 4, 0, 32'd5);    set_kat(32'h4052_5193, 2'b00); step(); check("srai_accept", last_acc, 1);
        set_req(1, 48, 10, 11, 12, 32'd0); set_kat(32'h02C5_8533, 2'b00); step(); check("mul_accept", last_acc, 1);
        set_req(1, 46, 5, 3, 0, 32'h300);  set_kat(32'h3001_E2F3, 2'b00); step(); check("csrrsi_accept", last_acc, 1);
        req_valid = 0;
        step(); step();
        check("stream_throughput", hs_total - hs0, 4);

        // error words
        set_req(1, 2, 1, 0, 0, 32'd3);  set_kat(32'h0000_0013, 2'b10); step(); check("jal_bad_accept", last_acc, 1);
        set_req(1, 60, 1, 2, 3, 32'd0); set_kat(32'h0000_0013, 2'b01); step(); check("illegal_accept", last_acc, 1);
        req_valid = 0;
        repeat (3) step();
        check("err_count_two", err_count, 2);

        // backpressure: consumer stalls for 5 cycles while 3 requests are offered
        bp_op = '{27, 17, 0};
        bp_im = '{0, -4, 32'h1234_5000};
        hs0 = hs_total; idx = 0; req_ordy = 0;
        for (int t = 0; t < 5; t++) begin
            set_req(1, bp_op[idx > 2 ? 2 : idx], 5 + idx, 6, 7, bp_im[idx > 2 ? 2 : idx]);
            step();
            if (last_acc) idx++;
        end
        check("bp_accepted", idx, 2);
        check("bp_in_ready_low", ifc.in_ready, 0);
        req_ordy = 1;
        for (int t = 0; t < 10 && idx < 3; t++) begin
            set_req(1, bp_op[idx], 5 + idx, 6, 7, bp_im[idx]);
            step();
            if (last_acc) idx++;
        end
        check("bp_third_accepted", idx, 3);
        req_valid = 0;
        drain();
        check("bp_words_out", hs_total - hs0, 3);

        // flush with two words in flight
        req_ordy = 0;
        set_req(1, 18, 1, 1, 0, 32'd7);  step(); check("fl_acc0", last_acc, 1);
        set_req(1, 19, 2, 2, 0, 32'd9);  step(); check("fl_acc1", last_acc, 1);
        enc_before = enc_count; hs0 = hs_total;
        req_flush = 1;
        set_req(1, 20, 3, 3, 0, 32'd11); step(); check("flush_no_accept", last_acc, 0);
        req_flush = 0; req_valid = 0; req_ordy = 1;
        step(); check("flush_valid_clear", ifc.out_valid, 0);
        repeat (4) step();
        check("flush_no_words", hs_total - hs0, 0);
        check("flush_enc_kept", enc_count, enc_before);

        // reset mid-stream
        for (int t = 0; t < 3; t++) begin
            set_req(1, 18 + t, t + 1, t + 2, 0, 32'(t));
            step();
        end
        req_rstn = 0; step();
        req_rstn = 1; req_valid = 0; step();
        check("mid_rst_valid", ifc.out_valid, 0);
        check("mid_rst_code", ifc.out_code, 0);
        check("mid_rst_err", ifc.out_err, 0);
        check("mid_rst_enc", enc_count, 0);
        check("mid_rst_errc", err_count, 0);
        set_req(1, 18, 1, 2, 0, 32'hFFFF_FFFF); set_kat(32'hFFF1_0093, 2'b00);
        step(); check("post_rst_accept", last_acc, 1);
        req_valid = 0;
        step(); check("post_rst_lat1", ifc.out_valid, 0);
        step(); check("post_rst_lat2", ifc.out_valid, 1);

        // randomized traffic
        for (int t = 0; t < 400; t++) begin
            set_req($urandom_range(0, 9) < 7, $urandom_range(0, 63), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31), rand_imm());
            req_ordy  = ($urandom_range(0, 3) != 0);
            req_flush = ($urandom_range(0, 49) == 0);
            step();
        end
        req_flush = 0; req_valid = 0; req_ordy = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
